// File: rtl/multicycle_seq.sv
// multicycle_seq: multi-cycle RV32I control sequencer (fetch, decode wait, exec, mem, writeback, PC update)
// All outputs come from registers loaded with the next-state view, so they change one edge after a decision.
module multicycle_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] ir_o,
    input  logic [5:0]  dec_op_i,
    input  logic [31:0] imm_i,
    input  logic        branch_taken_i,
    output logic        alu_en_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    input  logic        dmem_ready_i,
    output logic        rf_we_o,
    output logic [31:0] pc_o,
    output logic [31:0] retired_o,
    output logic        trap_o
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
    typedef enum logic [2:0] {C_ALU, C_LOAD, C_STORE, C_BR, C_JAL, C_BAD} cls_t;

    state_t      state_q, state_d;
    cls_t        cls_q, op_cls;
    logic [31:0] pc_q, ir_q, imm_q, retired_q, tgt;
    logic [7:0]  cnt_q, cnt_d;
    logic        take_q, take_now, take, misaligned, retire;
    logic        fetch_wait, fetch_done, mem_wait, mem_done, timed_out;
    logic        imem_req_q, alu_en_q, dmem_req_q, dmem_we_q, rf_we_q, trap_q;
    logic        imem_req_d, alu_en_d, dmem_req_d, dmem_we_d, rf_we_d, trap_d;

    // lui/auipc only need a writeback slot, so they share the ALU class
    assign op_cls = (dec_op_i <= 6'h12) ? C_ALU :
                    (dec_op_i <= 6'h17) ? C_LOAD :
                    (dec_op_i <= 6'h1A) ? C_STORE :
                    (dec_op_i <= 6'h1D || dec_op_i == 6'h20) ? C_BR :
                    (dec_op_i == 6'h21) ? C_JAL :
                    (dec_op_i == 6'h22 || dec_op_i == 6'h23) ? C_ALU : C_BAD;

    // Redirect is decided in EXEC (live branch_taken) and remembered for a jal retiring in WB
    assign take_now   = (cls_q == C_JAL) || (cls_q == C_BR && branch_taken_i);
    assign take       = (state_q == S_EXEC) ? take_now : take_q;
    assign tgt        = pc_q + (take ? imm_q : 32'd4);
    assign misaligned = tgt[1:0] != 2'b00;

    assign fetch_wait = state_q == S_FETCH && imem_req_q && !imem_ready_i;
    assign fetch_done = state_q == S_FETCH && imem_req_q && imem_ready_i;
    assign mem_wait   = state_q == S_MEM && dmem_req_q && !dmem_ready_i;
    assign mem_done   = state_q == S_MEM && dmem_req_q && dmem_ready_i;
    assign timed_out  = (fetch_wait || mem_wait) && cnt_q == 8'(TIMEOUT - 1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_FETCH;
            cnt_q      <= '0;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            imm_q      <= '0;
            cls_q      <= C_ALU;
            take_q     <= 1'b0;
            retired_q  <= '0;
            imem_req_q <= 1'b0;
            alu_en_q   <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            trap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= retire ? tgt : pc_q;
            retired_q  <= retire ? retired_q + 32'd1 : retired_q;
            ir_q       <= fetch_done ? imem_rdata_i : ir_q;
            imm_q      <= (state_q == S_DECODE) ? imm_i : imm_q;
            cls_q      <= (state_q == S_DECODE) ? op_cls : cls_q;
            take_q     <= (state_q == S_EXEC) ? take_now : take_q;
            imem_req_q <= imem_req_d;
            alu_en_q   <= alu_en_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            rf_we_q    <= rf_we_d;
            trap_q     <= trap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  state_d = timed_out ? S_TRAP : fetch_done ? S_DECODE : S_FETCH;
            S_DECODE: state_d = (op_cls == C_BAD) ? S_TRAP : S_EXEC;
            S_EXEC: begin
                if (cls_q == C_LOAD || cls_q == C_STORE) state_d = S_MEM;
                else if (misaligned) state_d = S_TRAP;
                else if (cls_q == C_BR) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else state_d = S_WB;
            end
            S_MEM: begin
                if (timed_out) state_d = S_TRAP;
                else if (mem_done) begin
                    state_d = (cls_q == C_STORE) ? S_FETCH : S_WB;
                    retire  = cls_q == C_STORE;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:  state_d = S_TRAP;
        endcase
        cnt_d = (state_d != state_q) ? 8'd0 : (fetch_wait || mem_wait) ? cnt_q + 8'd1 : cnt_q;
    end

    always_comb begin
        imem_req_d = state_d == S_FETCH;
        alu_en_d   = state_d == S_EXEC;
        dmem_req_d = state_d == S_MEM;
        dmem_we_d  = state_d == S_MEM && cls_q == C_STORE;
        rf_we_d    = state_d == S_WB;
        trap_d     = state_d == S_TRAP;
    end

    assign imem_req_o  = imem_req_q;
    assign imem_addr_o = pc_q;
    assign ir_o        = ir_q;
    assign alu_en_o    = alu_en_q;
    assign dmem_req_o  = dmem_req_q;
    assign dmem_we_o   = dmem_we_q;
    assign rf_we_o     = rf_we_q;
    assign pc_o        = pc_q;
    assign retired_o   = retired_q;
    assign trap_o      = trap_q;
endmodule
